// File: rtl/ascon_perm_iter.sv
// Iterative Ascon permutation: one full round (pc, ps, pl) per clock on a 320-bit state register.
// Serves pa (start at round 0) and pb (start at round 6); rounds always finish at index 11.

module pl (
  input  logic [0:4][63:0] x,
  output logic [0:4][63:0] y
);

  function automatic logic [63:0] rotr(input logic [63:0] v, input int n);
    return (v >> n) | (v << (64 - n));
  endfunction

  always_comb begin
    y[0] = x[0] ^ rotr(x[0], 19) ^ rotr(x[0], 28);
    y[1] = x[1] ^ rotr(x[1], 61) ^ rotr(x[1], 39);
    y[2] = x[2] ^ rotr(x[2], 1)  ^ rotr(x[2], 6);
    y[3] = x[3] ^ rotr(x[3], 10) ^ rotr(x[3], 17);
    y[4] = x[4] ^ rotr(x[4], 7)  ^ rotr(x[4], 41);
  end

endmodule

module ascon_perm_iter (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic [3:0]       round_start_i,
  input  logic [0:4][63:0] state_i,
  output logic             ready_o,
  output logic             done_o,
  output logic [3:0]       round_o,
  output logic [0:4][63:0] state_o
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

  fsm_t             fsm_p0;
  logic [0:4][63:0] state_p0;
  logic [3:0]       round_p0;
  logic [0:4][63:0] pc_out;
  logic [0:4][63:0] ps_out;
  logic [0:4][63:0] pl_out;

  // Bitsliced form of the 5-bit S-box, x0 is the column MSB.
  function automatic logic [0:4][63:0] sbox_layer(input logic [0:4][63:0] s);
    logic [63:0] x0, x1, x2, x3, x4;
    logic [63:0] t0, t1, t2, t3, t4;
    x0 = s[0]; x1 = s[1]; x2 = s[2]; x3 = s[3]; x4 = s[4];
    x0 = x0 ^ x4;
    x4 = x4 ^ x3;
    x2 = x2 ^ x1;
    t0 = ~x0 & x1;
    t1 = ~x1 & x2;
    t2 = ~x2 & x3;
    t3 = ~x3 & x4;
    t4 = ~x4 & x0;
    x0 = x0 ^ t1;
    x1 = x1 ^ t2;
    x2 = x2 ^ t3;
    x3 = x3 ^ t4;
    x4 = x4 ^ t0;
    x1 = x1 ^ x0;
    x0 = x0 ^ x4;
    x3 = x3 ^ x2;
    x2 = ~x2;
    return {x0, x1, x2, x3, x4};
  endfunction

  always_comb begin
    pc_out = state_p0;
    pc_out[2][7:0] = state_p0[2][7:0] ^ {4'hF - round_p0, round_p0};
  end

  assign ps_out = sbox_layer(pc_out);

  pl u_pl (
    .x (ps_out),
    .y (pl_out)
  );

  // Stage p0: state and round registers, advanced once per round while running.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      fsm_p0   <= IDLE;
      state_p0 <= '0;
      round_p0 <= 4'd0;
    end else begin
      case (fsm_p0)
        IDLE: begin
          if (start_i) begin
            state_p0 <= state_i;
            round_p0 <= round_start_i;
            fsm_p0   <= (round_start_i <= 4'd11) ? RUN : DONE;
          end
        end
        RUN: begin
          state_p0 <= pl_out;
          if (round_p0 == 4'd11) begin
            fsm_p0 <= DONE;
          end else begin
            round_p0 <= round_p0 + 4'd1;
          end
        end
        DONE: begin
          fsm_p0 <= IDLE;
        end
        default: begin
          fsm_p0 <= IDLE;
        end
      endcase
    end
  end

  assign ready_o = (fsm_p0 == IDLE);
  assign done_o  = (fsm_p0 == DONE);
  assign round_o = round_p0;
  assign state_o = state_p0;

endmodule

// File: tb/tb_ascon_perm_iter.sv
// Bench for ascon_perm_iter: table-driven permutation model, per-cycle expectation queue, directed runs.

module tb_ascon_perm_iter;

  typedef logic [0:4][63:0] st_t;

  typedef struct {
    logic       ready;
    logic       done;
    logic [3:0] rnd;
    st_t        st;
  } exp_t;

  localparam logic [4:0] SBOX [0:31] = '{
    5'h04, 5'h0B, 5'h1F, 5'h14, 5'h1A, 5'h15, 5'h09, 5'h02,
    5'h1B, 5'h05, 5'h08, 5'h12, 5'h1D, 5'h03, 5'h06, 5'h1C,
    5'h1E, 5'h13, 5'h07, 5'h0E, 5'h00, 5'h0D, 5'h11, 5'h18,
    5'h10, 5'h0C, 5'h01, 5'h19, 5'h16, 5'h0A, 5'h0F, 5'h17};
  localparam int RA [0:4] = '{19, 61, 1, 10, 7};
  localparam int RB [0:4] = '{28, 39, 6, 17, 41};

  logic       clock_i;
  logic       reset_i;
  logic       start_i;
  logic [3:0] round_start_i;
  st_t        state_i;
  logic       ready_o;
  logic       done_o;
  logic [3:0] round_o;
  st_t        state_o;

  int   total = 0;
  int   bad   = 0;
  bit   check_en = 0;
  exp_t cur;
  exp_t q[$];

  ascon_perm_iter dut (
    .clock_i       (clock_i),
    .reset_i       (reset_i),
    .start_i       (start_i),
    .round_start_i (round_start_i),
    .state_i       (state_i),
    .ready_o       (ready_o),
    .done_o        (done_o),
    .round_o       (round_o),
    .state_o       (state_o)
  );

  initial begin
    clock_i = 1'b0;
    forever #5 clock_i = ~clock_i;
  end

  task automatic chk(input string name, input logic [319:0] act, input logic [319:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic int pc_const(input int r);
    return ((15 - r) << 4) | r;
  endfunction

  function automatic logic [63:0] ror(input logic [63:0] x, input int n);
    logic [127:0] d;
    d = {x, x} >> n;
    return d[63:0];
  endfunction

  function automatic st_t model_round(input st_t s, input int r);
    st_t        t;
    st_t        y;
    logic [4:0] col;
    logic [4:0] o;
    s[2] = s[2] ^ 64'(pc_const(r));
    for (int b = 0; b < 64; b++) begin
      col = {s[0][b], s[1][b], s[2][b], s[3][b], s[4][b]};
      o = SBOX[col];
      for (int i = 0; i < 5; i++) t[i][b] = o[4-i];
    end
    for (int i = 0; i < 5; i++) y[i] = t[i] ^ ror(t[i], RA[i]) ^ ror(t[i], RB[i]);
    return y;
  endfunction

  function automatic st_t model_perm(input st_t s, input int r0);
    for (int r = r0; r <= 11; r++) s = model_round(s, r);
    return s;
  endfunction

  // Expected outputs for every cycle, built as a whole schedule at each accept.
  initial begin
    cur = '{1'b1, 1'b0, 4'd0, '0};
    forever begin
      @(posedge clock_i or posedge reset_i);
      if (reset_i) begin
        q.delete();
        cur = '{1'b1, 1'b0, 4'd0, '0};
      end else if (cur.ready && start_i) begin
        st_t s;
        int  r0;
        s  = state_i;
        r0 = int'(round_start_i);
        if (r0 <= 11) begin
          for (int r = r0; r <= 11; r++) begin
            q.push_back('{1'b0, 1'b0, 4'(r), s});
            s = model_round(s, r);
          end
          q.push_back('{1'b0, 1'b1, 4'd11, s});
        end else begin
          q.push_back('{1'b0, 1'b1, 4'(r0), s});
        end
        cur = q.pop_front();
      end else if (q.size() > 0) begin
        cur = q.pop_front();
      end else begin
        cur.ready = 1'b1;
        cur.done  = 1'b0;
      end
    end
  end

  always @(negedge clock_i) begin
    if (check_en) begin
      chk("cyc_ready", ready_o, cur.ready);
      chk("cyc_done",  done_o,  cur.done);
      chk("cyc_round", round_o, cur.rnd);
      chk("cyc_state", state_o, cur.st);
    end
  end

  // Entered at a negedge with the DUT idle; returns at the first negedge with ready_o=1 again.
  task automatic do_run(input logic [3:0] r0, input st_t s, input bit disturb, output st_t res);
    int         cyc, ndone, dcyc, low, nexp;
    logic [3:0] rdone;
    bit         ok;
    nexp  = (r0 <= 4'd11) ? 13 - int'(r0) : 1;
    res   = model_perm(s, (r0 <= 4'd11) ? int'(r0) : 12);
    ndone = 0; dcyc = -1; low = 0; ok = 0; rdone = 4'hx;
    start_i = 1'b1; round_start_i = r0; state_i = s;
    @(negedge clock_i);
    start_i = 1'b0; round_start_i = ~r0; state_i = ~s;
    cyc = 1;
    while (cyc <= 40) begin
      if (disturb && (cyc == 3 || cyc == 13)) begin
        start_i = 1'b1;
        state_i = s ^ {5{64'h5A5A_C3C3_0F0F_9696}};
      end else begin
        start_i = 1'b0;
      end
      if (done_o) begin
        ndone++;
        dcyc  = cyc;
        rdone = round_o;
      end
      if (ready_o) begin
        ok = 1;
        break;
      end
      low++;
      @(negedge clock_i);
      cyc++;
    end
    start_i = 1'b0;
    chk("ready_returns", ok, 1'b1);
    chk("done_cycle", dcyc, nexp);
    chk("done_count", ndone, 1);
    chk("ready_low_cycles", low, nexp);
    chk("round_at_done", rdone, (r0 <= 4'd11) ? 4'd11 : r0);
    chk("final_state", state_o, res);
  endtask

  initial begin
    st_t init, zero, r_pa, r1, r2, rtmp;
    st_t lit1;
    int  nd;
    init = {64'h80400C0600000000, 64'h0001020304050607, 64'h08090A0B0C0D0E0F,
            64'h0001020304050607, 64'h08090A0B0C0D0E0F};
    zero = '0;
    lit1 = {64'h000964B00000004B, 64'h0000000096000213, 64'h53FFFFFFFFFFFF90,
            64'h12E580000000004B, 64'h0000000000000000};

    reset_i = 1'b0; start_i = 1'b0; round_start_i = 4'd0; state_i = '0;
    #2 reset_i = 1'b1;
    repeat (2) @(negedge clock_i);
    chk("reset_ready", ready_o, 1'b1);
    chk("reset_done",  done_o,  1'b0);
    chk("reset_round", round_o, 4'd0);
    chk("reset_state", state_o, 320'd0);
    reset_i  = 1'b0;
    check_en = 1;

    chk("model_pc_r0",  pc_const(0),  32'hF0);
    chk("model_pc_r6",  pc_const(6),  32'h96);
    chk("model_pc_r11", pc_const(11), 32'h4B);
    chk("model_single_round", model_round(zero, 11), lit1);

    do_run(4'd11, zero, 0, rtmp);
    chk("single_round_literal", state_o, lit1);

    do_run(4'd0, init, 0, r_pa);

    do_run(4'd6, init, 0, r1);
    do_run(4'd6, r1, 0, r2);
    chk("pb_chain_model", r2, model_perm(model_perm(init, 6), 6));

    do_run(4'd0, init, 1, rtmp);
    chk("disturbed_pa_same", state_o, r_pa);

    do_run(4'd12, init, 0, rtmp);
    chk("oor12_state", state_o, init);
    chk("oor12_round", round_o, 4'd12);
    do_run(4'd15, r1, 0, rtmp);
    chk("oor15_state", state_o, r1);
    chk("oor15_round", round_o, 4'd15);

    start_i = 1'b1; round_start_i = 4'd0; state_i = init;
    @(negedge clock_i);
    start_i = 1'b0;
    repeat (5) @(negedge clock_i);
    chk("pre_reset_round", round_o, 4'd5);
    #1 reset_i = 1'b1;
    #1;
    chk("midreset_state", state_o, 320'd0);
    chk("midreset_ready", ready_o, 1'b1);
    chk("midreset_done",  done_o,  1'b0);
    chk("midreset_round", round_o, 4'd0);
    @(negedge clock_i);
    reset_i = 1'b0;
    nd = 0;
    repeat (6) begin
      @(negedge clock_i);
      if (done_o) nd++;
    end
    chk("no_done_after_reset", nd, 0);
    do_run(4'd6, init, 0, rtmp);

    repeat (2) @(negedge clock_i);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1, "bench stalled");
  end

endmodule
